// File: rtl/reg_pipe_vr.sv
// reg_pipe_vr: DEPTH-stage valid/ready register pipeline with bubble
// collapsing, synchronous flush and a registered occupancy count.
// Each stage is a WIDTH-bit data register plus a valid bit. Stage 0 is
// fed from the input and stage DEPTH-1 drives the output.

module reg_pipe_vr #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [DEPTH-1:0] advance;
    logic             inFire;
    logic             outFire;

    // Walk from the output back to stage 0: a stage moves on when the slot after it is free
    always_comb begin : advanceChain
        logic slotFree;
        slotFree = out_ready;
        advance  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            advance[i] = valid_q[i] && slotFree;
            slotFree   = !valid_q[i] || slotFree;
        end
    end

    assign in_ready  = !flush && (!valid_q[0] || advance[0]);
    assign inFire    = in_valid && in_ready;
    assign outFire   = valid_q[DEPTH-1] && out_ready && !flush;
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

    // Next-state: flush wins over everything; otherwise shift stages that advance and hold the rest
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            valid_d[0] = inFire || (valid_q[0] && !advance[0]);
            if (inFire) begin
                data_d[0] = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = advance[i-1] || (valid_q[i] && !advance[i]);
                if (advance[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
            count_d = count_q + CW'(inFire) - CW'(outFire);
        end
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule
